lcd_write_arbiter: RTL and testbench

- Shares the single character-write port of the LCD controller between two requesters: the processor (lcd write enable/data) and the PS/2 keyboard echo path (key-pressed strobe/scan byte).
- Each requester has a small FIFO. A round-robin scheduler issues one-cycle write pulses to the LCD controller, spaced by a programmable gap so the controller finishes each character.
- Sits at top level between processor/PS2_Interface and lcd.

---
 rtl/lcd_write_arbiter.sv | 96 +++++++++
 tb/tb_lcd_write_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: shares the LCD character-write port between the CPU and the keyboard echo path
// Ports: clock/reset (async, active-high); cpu_wr_en/cpu_wr_data/cpu_full (CPU side);
// kbd_pressed/kbd_data/kbd_drop (keyboard side); lcd_wr_en/lcd_wr_data (to lcd); busy.
// Define LCD_ARB_CPU_PRIORITY_EN for strict CPU priority instead of round-robin.
module lcd_write_arbiter #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_wr_en,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_full,
    input  logic              kbd_pressed,
    input  logic [DATA_W-1:0] kbd_data,
    output logic              kbd_drop,
    output logic              lcd_wr_en,
    output logic [DATA_W-1:0] lcd_wr_data,
    output logic              busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t state, next_state;
    logic [DATA_W-1:0] cpu_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] kbd_mem [FIFO_DEPTH];
    logic [AW-1:0] cpu_wp, cpu_rp, kbd_wp, kbd_rp;
    logic [CW-1:0] cpu_cnt, kbd_cnt;
    logic [GW-1:0] gap_cnt;
    logic kbd_prev, rr_last_kbd;
    logic cpu_push, cpu_pop, kbd_rise, kbd_full, kbd_push, kbd_pop;
    logic cpu_ne, kbd_ne, grant, grant_cpu;
    assign cpu_full = cpu_cnt == CW'(FIFO_DEPTH);
    assign kbd_full = kbd_cnt == CW'(FIFO_DEPTH);
    assign cpu_ne   = cpu_cnt != '0;
    assign kbd_ne   = kbd_cnt != '0;
    // full is judged before any same-edge pop, so a full FIFO always refuses
    assign cpu_push = cpu_wr_en & ~cpu_full;
    assign kbd_rise = kbd_pressed & ~kbd_prev;
    assign kbd_push = kbd_rise & ~kbd_full;
    assign grant    = (state == IDLE) & (cpu_ne | kbd_ne);
`ifdef LCD_ARB_CPU_PRIORITY_EN
    assign grant_cpu = cpu_ne;
`else
    assign grant_cpu = cpu_ne & (~kbd_ne | rr_last_kbd);
`endif
    assign cpu_pop = grant & grant_cpu;
    assign kbd_pop = grant & ~grant_cpu;
    always_ff @(posedge clock) begin
        if (cpu_push) cpu_mem[cpu_wp] <= cpu_wr_data;
        if (kbd_push) kbd_mem[kbd_wp] <= kbd_data;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_wp      <= '0;
            cpu_rp      <= '0;
            cpu_cnt     <= '0;
            kbd_wp      <= '0;
            kbd_rp      <= '0;
            kbd_cnt     <= '0;
            kbd_prev    <= 1'b0;
            kbd_drop    <= 1'b0;
            rr_last_kbd <= 1'b1;
            lcd_wr_data <= '0;
            gap_cnt     <= '0;
        end else begin
            cpu_wp      <= cpu_wp + AW'(cpu_push);
            cpu_rp      <= cpu_rp + AW'(cpu_pop);
            cpu_cnt     <= cpu_cnt + CW'(cpu_push) - CW'(cpu_pop);
            kbd_wp      <= kbd_wp + AW'(kbd_push);
            kbd_rp      <= kbd_rp + AW'(kbd_pop);
            kbd_cnt     <= kbd_cnt + CW'(kbd_push) - CW'(kbd_pop);
            kbd_prev    <= kbd_pressed;
            kbd_drop    <= kbd_rise & kbd_full;
            rr_last_kbd <= grant ? ~grant_cpu : rr_last_kbd;
            lcd_wr_data <= grant ? (grant_cpu ? cpu_mem[cpu_rp] : kbd_mem[kbd_rp]) : lcd_wr_data;
            gap_cnt     <= state == ISSUE ? GW'(GAP_CYCLES - 1) :
                           (state == GAP && gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end
    always_comb begin
        next_state = state == IDLE  ? (grant ? ISSUE : IDLE) :
                     state == ISSUE ? GAP :
                     (state == GAP && gap_cnt != '0) ? GAP : IDLE;
    end
    always_comb begin
        lcd_wr_en = state == ISSUE;
        busy      = (state != IDLE) | cpu_ne | kbd_ne;
    end
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: queue-based model plus directed literal checks for lcd_write_arbiter
module tb_lcd_write_arbiter;
    localparam int G = 4;
    localparam int D = 4;
    logic clock = 1'b0, reset = 1'b1, cpu_wr_en = 1'b0, kbd_pressed = 1'b0;
    logic [7:0] cpu_wr_data = '0, kbd_data = '0;
    logic cpu_full, kbd_drop, lcd_wr_en, busy;
    logic [7:0] lcd_wr_data;
    int tests = 0, fails = 0, drops = 0, full_seen = 0;
    logic [7:0] cq[$], kq[$], log_d[$], exp_q[$];
    int log_t[$];
    int cool = 0, cyc = 0;
    logic m_en = 1'b0, m_drop = 1'b0, last_kbd = 1'b1, kprev = 1'b0, take_cpu, cfull, kfull, rise;
    logic [7:0] m_data = '0;
    always #5 clock = ~clock;
    lcd_write_arbiter #(.DATA_W(8), .FIFO_DEPTH(D), .GAP_CYCLES(G)) dut (
        .clock(clock), .reset(reset), .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data),
        .cpu_full(cpu_full), .kbd_pressed(kbd_pressed), .kbd_data(kbd_data), .kbd_drop(kbd_drop),
        .lcd_wr_en(lcd_wr_en), .lcd_wr_data(lcd_wr_data), .busy(busy)
    );
    // Model: after a write the arbiter is unavailable for G+1 further edges.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cq.delete(); kq.delete();
            cool = 0; cyc = 0; m_en = 0; m_data = 0; m_drop = 0; kprev = 0; last_kbd = 1;
        end else begin
            cyc++;
            cfull = cq.size() == D;
            kfull = kq.size() == D;
            rise = kbd_pressed && !kprev;
            m_en = 0;
            if (cool > 0) cool--;
            else if (cq.size() > 0 || kq.size() > 0) begin
`ifdef LCD_ARB_CPU_PRIORITY_EN
                take_cpu = cq.size() > 0;
`else
                take_cpu = cq.size() > 0 && (kq.size() == 0 || last_kbd);
`endif
                m_data = take_cpu ? cq.pop_front() : kq.pop_front();
                last_kbd = !take_cpu;
                m_en = 1;
                cool = G + 1;
            end
            if (cpu_wr_en && !cfull) cq.push_back(cpu_wr_data);
            m_drop = rise && kfull;
            if (rise && !kfull) kq.push_back(kbd_data);
            kprev = kbd_pressed;
        end
    end
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", n, a, e);
        end
    endtask
    task automatic tick();
        @(negedge clock);
        chk("wr_en", 32'(lcd_wr_en), 32'(m_en));
        chk("wr_data", 32'(lcd_wr_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(cool > 0 || cq.size() > 0 || kq.size() > 0));
        chk("cpu_full", 32'(cpu_full), 32'(cq.size() == D));
        chk("kbd_drop", 32'(kbd_drop), 32'(m_drop));
        if (lcd_wr_en) begin log_d.push_back(lcd_wr_data); log_t.push_back(cyc); end
        if (kbd_drop) drops++;
        if (cpu_full) full_seen++;
    endtask
    task automatic clear_log();
        log_d.delete(); log_t.delete(); drops = 0; full_seen = 0;
    endtask
    task automatic do_reset();
        reset = 1; tick(); tick(); reset = 0; clear_log();
    endtask
    task automatic drain();
        int n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        chk("drain_timeout", 32'(busy), 0);
        repeat (3) tick();
    endtask
    task automatic check_seq(string n, logic [7:0] e[$]);
        chk({n, "_len"}, 32'(log_d.size()), 32'(e.size()));
        foreach (e[i]) if (i < log_d.size()) chk(n, 32'(log_d[i]), 32'(e[i]));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end
    initial begin
        // reset values and single-byte latency
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_en", 32'(lcd_wr_en), 0);
        chk("rst_data", 32'(lcd_wr_data), 0);
        while (cyc < 9) tick();
        cpu_wr_en = 1; cpu_wr_data = 8'h41; tick(); cpu_wr_en = 0;
        while (cyc < 15) tick();
        chk("t1_busy15", 32'(busy), 1);
        tick();
        chk("t1_busy16", 32'(busy), 0);
        exp_q = '{8'h41}; check_seq("t1_seq", exp_q);
        if (log_t.size() > 0) chk("t1_edge", 32'(log_t[0]), 11);
        // interleaving of two preloaded requesters
        do_reset();
        cpu_wr_en = 1; cpu_wr_data = 8'h41; kbd_pressed = 1; kbd_data = 8'h61; tick();
        cpu_wr_data = 8'h42; kbd_pressed = 0; tick();
        cpu_wr_en = 0; kbd_pressed = 1; kbd_data = 8'h62; tick();
        kbd_pressed = 0; drain();
`ifdef LCD_ARB_CPU_PRIORITY_EN
        exp_q = '{8'h41, 8'h42, 8'h61, 8'h62};
`else
        exp_q = '{8'h41, 8'h61, 8'h42, 8'h62};
`endif
        check_seq("t2_seq", exp_q);
        for (int i = 0; i + 1 < log_t.size(); i++) chk("t2_spacing", 32'(log_t[i+1] - log_t[i]), G + 2);
        // held strobe pushes once
        do_reset();
        kbd_pressed = 1; kbd_data = 8'h33; repeat (10) tick();
        kbd_pressed = 0; drain();
        exp_q = '{8'h33}; check_seq("t3_seq", exp_q);
        // overflow of both FIFOs
        do_reset();
        for (int n = 0; n < 12; n++) begin
            cpu_wr_en = n < 6; cpu_wr_data = 8'(8'h10 + n);
            kbd_pressed = (n % 2 == 0) && n <= 10;
            kbd_data = n == 10 ? 8'h7A : 8'(8'h60 + n / 2);
            tick();
        end
        cpu_wr_en = 0; kbd_pressed = 0; drain();
`ifdef LCD_ARB_CPU_PRIORITY_EN
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h60, 8'h61, 8'h62, 8'h63};
        chk("t4_drops", 32'(drops), 2);
`else
        exp_q = '{8'h10, 8'h60, 8'h11, 8'h61, 8'h12, 8'h62, 8'h13, 8'h63, 8'h14, 8'h64};
        chk("t4_drops", 32'(drops), 1);
`endif
        check_seq("t4_seq", exp_q);
        chk("t4_full_seen", 32'(full_seen > 0), 1);
        // reset during GAP with bytes queued
        do_reset();
        for (int n = 0; n < 5; n++) begin cpu_wr_en = 1; cpu_wr_data = 8'(8'h20 + n); tick(); end
        cpu_wr_en = 0;
        chk("t5_pre_full", 32'(cpu_full), 1);
        chk("t5_pre_busy", 32'(busy), 1);
        reset = 1; #1;
        chk("t5_rst_en", 32'(lcd_wr_en), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_full", 32'(cpu_full), 0);
        tick(); reset = 0; clear_log();
        repeat (20) tick();
        chk("t5_quiet", 32'(log_d.size()), 0);
        cpu_wr_en = 1; cpu_wr_data = 8'h55; kbd_pressed = 1; kbd_data = 8'h66; tick();
        cpu_wr_en = 0; kbd_pressed = 0; drain();
        exp_q = '{8'h55, 8'h66}; check_seq("t5_seq", exp_q);
        // ten bytes through the CPU FIFO, wrapping the pointers
        do_reset();
        begin
            int sent = 0, guard = 0;
            while (sent < 10 && guard < 500) begin
                if (!cpu_full) begin cpu_wr_en = 1; cpu_wr_data = 8'(8'h30 + sent); sent++; end
                else cpu_wr_en = 0;
                tick(); guard++;
            end
            chk("t6_sent", 32'(sent), 10);
        end
        cpu_wr_en = 0; drain();
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check_seq("t6_seq", exp_q);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
